// File: rtl/flanken_generator_pkg.sv
// Shared types and default widths for the pulse-burst generator and its phase timer.
package flanken_generator_pkg;

  localparam int CNT_W_DEF  = 8;
  localparam int TIME_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/flanken_phase_timer.sv
// Down-counter timing one HIGH or LOW phase; tick marks the last cycle of the phase.
module flanken_phase_timer
  import flanken_generator_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [TIME_W-1:0] value,
  output logic              tick
);

  logic [TIME_W-1:0] cnt_q, cnt_d;

  // A zero duration behaves like one cycle, so the load value never underflows.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (value == '0) ? '0 : value - TIME_W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TIME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/flanken_generator.sv
// Programmable burst of rectangular pulses: N pulses of H cycles high, L cycles low.
module flanken_generator
  import flanken_generator_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [CNT_W-1:0]  pulse_count,
  input  logic [TIME_W-1:0] high_cycles,
  input  logic [TIME_W-1:0] low_cycles,
  output logic              signal,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TIME_W-1:0] high_q, high_d;
  logic [TIME_W-1:0] low_q, low_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              signal_q, signal_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tmr_load;
  logic [TIME_W-1:0] tmr_value;
  logic              tmr_tick;

  flanken_phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .tick    (tmr_tick)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    high_d    = high_q;
    low_d     = low_q;
    sent_d    = sent_q;
    signal_d  = signal_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = high_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = pulse_count;
          high_d = high_cycles;
          low_d  = low_cycles;
          sent_d = '0;
          if (pulse_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = ST_HIGH;
            signal_d  = 1'b1;
            busy_d    = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = high_cycles;
          end
        end
      end
      ST_HIGH: begin
        // Abort beats the phase end: a cut-short high phase is never counted.
        if (stop) begin
          state_d  = ST_IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
        end else if (tmr_tick) begin
          state_d   = ST_LOW;
          signal_d  = 1'b0;
          sent_d    = sent_q + CNT_W'(1);
          tmr_load  = 1'b1;
          tmr_value = low_q;
        end
      end
      ST_LOW: begin
        if (stop) begin
          state_d  = ST_IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
        end else if (tmr_tick) begin
          if (sent_q == cnt_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = ST_HIGH;
            signal_d  = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = high_q;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      high_q   <= '0;
      low_q    <= '0;
      sent_q   <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      high_q   <= high_d;
      low_q    <= low_d;
      sent_q   <= sent_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign signal = signal_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign sent   = sent_q;

endmodule

// File: tb/tb_flanken_generator.sv
// Self-checking bench for flanken_generator: directed table, reset corner, random bursts.
module tb_flanken_generator;
  localparam int CNT_W  = 8;
  localparam int TIME_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [CNT_W-1:0]  pulse_count = '0;
  logic [TIME_W-1:0] high_cycles = '0;
  logic [TIME_W-1:0] low_cycles = '0;
  logic              signal, busy, done;
  logic [CNT_W-1:0]  sent;

  flanken_generator #(.CNT_W(CNT_W), .TIME_W(TIME_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .pulse_count(pulse_count), .high_cycles(high_cycles), .low_cycles(low_cycles),
    .signal(signal), .busy(busy), .done(done), .sent(sent)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct packed {
    logic       sig;
    logic       busy;
    logic       done;
    logic [7:0] sent;
  } obs_t;

  typedef struct {
    int n, h, l, stop_at, meddle_at, tail;
    int exp_rises, exp_dones, exp_sent;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected outputs in cycle c (c=0 is the first cycle after start is sampled).
  // Stop asserted during cycle s freezes sent at its cycle-s value and idles the line.
  function automatic obs_t model(input int c, input int n, input int he, input int le, input int s);
    obs_t o;
    int p, total, cc;
    o = '0;
    p = he + le;
    total = n * p;
    cc = (s >= 0 && c > s) ? s : c;
    if (n == 0) begin
      o.done = (c == 0);
      return o;
    end
    if (cc < total) o.sent = (cc >= he) ? 8'((cc - he) / p + 1) : 8'd0;
    else            o.sent = 8'(n);
    if (s >= 0 && c > s) return o;
    if (c < total) begin
      o.sig  = ((c % p) < he);
      o.busy = 1'b1;
    end else if (c == total) begin
      o.done = 1'b1;
    end
    return o;
  endfunction

  // Entered and left at posedge+1; start is raised in the current cycle.
  task automatic run_burst(input int n, input int h, input int l, input int s, input int m,
                           input int tail, output int rises, output int dones, output int last_sent);
    int he, le, total, last;
    logic prev;
    obs_t e;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    total = n * (he + le);
    last = (s >= 0) ? s + 2 : total + tail;
    pulse_count = CNT_W'(n);
    high_cycles = TIME_W'(h);
    low_cycles  = TIME_W'(l);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rises = 0; dones = 0; last_sent = 0; prev = 1'b0;
    for (int c = 0; c <= last; c++) begin
      stop = (c == s);
      if (c == m) begin
        start = 1'b1;
        high_cycles = TIME_W'(h + 3);
        low_cycles  = TIME_W'(l + 1);
        pulse_count = CNT_W'(n + 2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      e = model(c, n, he, le, s);
      check($sformatf("cyc%0d n%0d h%0d l%0d {sig,busy,done,sent}", c, n, h, l),
            int'({signal, busy, done, sent}), int'(e));
      if (signal && !prev) rises++;
      prev = signal;
      if (done) dones++;
      last_sent = int'(sent);
      @(posedge clk); #1;
    end
    stop = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    vec_t vecs[6];
    int r, d, st;

    vecs[0] = '{n:4,  h:5, l:5, stop_at:-1, meddle_at:-1, tail:0, exp_rises:4, exp_dones:1, exp_sent:4};
    vecs[1] = '{n:2,  h:1, l:3, stop_at:-1, meddle_at:-1, tail:2, exp_rises:2, exp_dones:1, exp_sent:2};
    vecs[2] = '{n:0,  h:7, l:7, stop_at:-1, meddle_at:-1, tail:2, exp_rises:0, exp_dones:1, exp_sent:0};
    vecs[3] = '{n:1,  h:0, l:0, stop_at:-1, meddle_at:-1, tail:2, exp_rises:1, exp_dones:1, exp_sent:1};
    vecs[4] = '{n:10, h:3, l:3, stop_at:13, meddle_at:-1, tail:0, exp_rises:3, exp_dones:0, exp_sent:2};
    vecs[5] = '{n:3,  h:4, l:2, stop_at:-1, meddle_at:5,  tail:2, exp_rises:3, exp_dones:1, exp_sent:3};

    #25;
    check("reset signal", int'(signal), 0);
    check("reset busy",   int'(busy),   0);
    check("reset done",   int'(done),   0);
    check("reset sent",   int'(sent),   0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i].n, vecs[i].h, vecs[i].l, vecs[i].stop_at, vecs[i].meddle_at,
                vecs[i].tail, r, d, st);
      check($sformatf("vec%0d rises", i), r,  vecs[i].exp_rises);
      check($sformatf("vec%0d dones", i), d,  vecs[i].exp_dones);
      check($sformatf("vec%0d sent", i),  st, vecs[i].exp_sent);
    end

    // Asynchronous reset in the second high phase of a 3x(2+2) burst.
    pulse_count = 8'd3; high_cycles = 16'd2; low_cycles = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mid-burst signal before reset", int'(signal), 1);
    check("mid-burst sent before reset",   int'(sent),   1);
    #2 reset_n = 1'b0;
    #1;
    check("async reset {sig,busy,done,sent}", int'({signal, busy, done, sent}), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("post-reset idle cyc%0d", c), int'({signal, busy, done, sent}), 0);
    end
    @(posedge clk); #1;

    for (int k = 0; k < 25; k++) begin
      int n, h, l, s, m, he, le, total;
      n = int'($urandom_range(5, 0));
      h = int'($urandom_range(4, 0));
      l = int'($urandom_range(4, 0));
      he = (h == 0) ? 1 : h;
      le = (l == 0) ? 1 : l;
      total = n * (he + le);
      s = -1;
      m = -1;
      if (total > 0) begin
        case ($urandom_range(2, 0))
          0: s = int'($urandom_range(total - 1, 0));
          1: m = int'($urandom_range(total - 1, 0));
          default: ;
        endcase
      end
      run_burst(n, h, l, s, m, int'($urandom_range(2, 0)), r, d, st);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
